dma_io_endpoint: RTL and testbench
==================================

// Module: dma_io_endpoint
// PURPOSE
//  Peripheral-side responder to the 8237A-style DMA channel. Raises DREQ, takes
//  DACK, then serves bus strobes: drives data on IOR_N, captures data on IOW_N.
//  Observes EOP_N to end a block. Holds an internal FIFO between the DMA bus and
//  a local valid/ready stream. Used as the device model and bench partner.
// PARAMETERS
//  DATA_W      8  width of the data bus and FIFO entries
//  FIFO_DEPTH  8  FIFO entries; power of 2, >=2
//  CNT_W       $clog2(FIFO_DEPTH)+1  occupancy counter width (derived, localparam)
// PORTS
//  CLK        in   1       system clock; all inputs synchronous to it
//  RESET      in   1       synchronous, active-high reset
//  enable     in   1       arms requests; low forces IDLE and clears tc_flag
//  dir        in   1       0: dev->mem (DMA issues IOR_N); 1: mem->dev (IOW_N)
//  demand     in   1       0: single mode; 1: demand mode (DREQ held across bytes)
//  DREQ       out  1       DMA request, registered
//  DACK       in   1       DMA acknowledge, active-high
//  IOR_N      in   1       I/O read strobe, active-low
//  IOW_N      in   1       I/O write strobe, active-low
//  EOP_N      in   1       end of process, active-low
//  DB_IN      in   DATA_W  bus data, captured during IOW_N
//  DB_OUT     out  DATA_W  bus data = FIFO head
//  DB_OE      out  1       DB_OUT enable = DACK & ~IOR_N & ~dir & state==XFER
//  src_valid/src_ready/src_data  in/out/in  1/1/DATA_W  local producer (dir=0)
//  snk_valid/snk_ready/snk_data  out/in/out 1/1/DATA_W  local consumer (dir=1)
//  tc_flag    out  1       sticky: EOP_N seen while DACK; cleared by enable=0
//  strobe_err out  1       1-cycle pulse: wrong-direction strobe under DACK
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, DREQ=0, DB_OE=0, DB_OUT=0, tc_flag=0,
//   strobe_err=0, snk_valid=0, src_ready=1.
//  ready(dir): dir=0 -> count>=1; dir=1 -> count<=FIFO_DEPTH-1.
//  FSM states (DmaPackage enum): IDLE, REQ, XFER, HOLD.
//  IDLE: DREQ=0. enable & ready & ~tc_flag -> REQ (DREQ=1 next cycle).
//  REQ: DREQ=1. DACK=1 -> XFER. enable=0 -> IDLE.
//  XFER: DREQ=1. Strobe low = active; complete on its low->high edge.
//   dir=0: DB_OE while IOR_N low; pop FIFO on IOR_N rise.
//   dir=1: latch DB_IN each cycle IOW_N low; push latched byte on IOW_N rise.
//   Complete: single -> HOLD, DREQ=0. Demand -> stay XFER if ready after the
//   update, else HOLD with DREQ=0.
//   DACK drops with no strobe active -> REQ if ready, else IDLE.
//  HOLD: DREQ=0. Wait DACK=0, then IDLE. Next request no sooner than 1 cycle later.
//  EOP_N=0 with DACK=1, any state: strobe still completes that cycle.
//   Set tc_flag, DREQ=0 next cycle, go HOLD. No new DREQ until enable toggles 0->1.
//  Wrong strobe (IOW_N low when dir=0, IOR_N low when dir=1) under DACK:
//   strobe_err pulse; no FIFO change.
//  FIFO: push and pop in the same cycle -> count unchanged, both accepted.
//   Pointers wrap mod FIFO_DEPTH. Bus push is never dropped: ready() gated DREQ.
//   Local side: src_ready=~full (dir=0); snk_valid=~empty (dir=1).
//  enable=0 or RESET mid-transfer: IDLE, DREQ=0 next edge. RESET also flushes
//   the FIFO; enable=0 keeps its contents.
//  DREQ latency: 1 cycle from the qualifying condition.
// STRUCTURE
//  DmaPackage: endpoint_state_t enum, dir_t enum (DEV2MEM, MEM2DEV).
//  Sub-module dma_sync_fifo #(DATA_W, FIFO_DEPTH): push/pop/full/empty/count,
//   synchronous RESET, head data always visible.
//  Top: FSM, strobe edge detect (registered IOR_N/IOW_N), bus muxing.
// TESTING
//  dir=0, single: push 0xA5,0x3C; DACK, IOR_N low 2 cycles -> DB_OUT=0xA5,
//   DB_OE=1; rise -> count=1; DREQ low until DACK drops, then reasserts.
//  dir=1, demand, depth 8: 8 IOW_N pulses 0x01..0x08 under one DACK -> DREQ
//   drops after 8th; snk stream yields 0x01..0x08 in order.
//  EOP_N low during 3rd IOR_N of demand burst -> 3rd byte popped, tc_flag=1,
//   DREQ=0; stays 0 until enable 0->1.
//  dir=0 with IOW_N pulsed under DACK -> strobe_err 1 cycle, count unchanged.
//  Full FIFO, dir=0: local push + bus pop same cycle -> count stays 8, order kept.
//  RESET asserted mid-XFER -> next edge DREQ=0, DB_OE=0, count=0, state IDLE.

Source files
------------

// File: rtl/dma_io_endpoint_pkg.sv
// Shared types for the DMA I/O endpoint: FSM states and transfer direction.
package dma_io_endpoint_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER,
      HOLD
   } endpoint_state_t;

   typedef enum logic {
      DEV2MEM = 1'b0,
      MEM2DEV = 1'b1
   } dir_t;

endpackage

// File: rtl/dma_io_endpoint_if.sv
// 8237A-style DMA bus between a channel (master) and a peripheral endpoint (slave).
interface dma_io_endpoint_if #(
   parameter int DATA_W = 8
);
   logic              DREQ;
   logic              DACK;
   logic              IOR_N;
   logic              IOW_N;
   logic              EOP_N;
   logic [DATA_W-1:0] DB_IN;
   logic [DATA_W-1:0] DB_OUT;
   logic              DB_OE;

   modport master (
      input  DREQ, DB_OUT, DB_OE,
      output DACK, IOR_N, IOW_N, EOP_N, DB_IN
   );

   modport slave (
      output DREQ, DB_OUT, DB_OE,
      input  DACK, IOR_N, IOW_N, EOP_N, DB_IN
   );
endinterface

// File: rtl/dma_io_endpoint_fifo.sv
// Synchronous FIFO with head always visible; simultaneous push/pop accepted even when full.
module dma_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  logic [DATA_W-1:0]             i_data,
   output logic [DATA_W-1:0]             o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic [$clog2(FIFO_DEPTH):0]   o_count_next
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push_ok;
   logic              w_pop_ok;

   assign o_full       = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_empty      = (r_count == '0);
   assign o_count      = r_count;
   assign o_data       = r_mem[r_rd_ptr];
   assign w_pop_ok     = i_pop & ~o_empty;
   assign w_push_ok    = i_push & (~o_full | w_pop_ok);
   assign o_count_next = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= o_count_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

// File: rtl/dma_io_endpoint.sv
// Peripheral-side DMA responder: DREQ/DACK handshake, IOR_N/IOW_N strobes, EOP handling,
// and a FIFO bridging the DMA bus to a local valid/ready stream.
module dma_io_endpoint
   import dma_io_endpoint_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              enable,
   input  logic              dir,
   input  logic              demand,
   dma_io_endpoint_if.slave  bus,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [DATA_W-1:0] src_data,
   output logic              snk_valid,
   input  logic              snk_ready,
   output logic [DATA_W-1:0] snk_data,
   output logic              tc_flag,
   output logic              strobe_err
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   endpoint_state_t   r_state;
   logic              r_dreq;
   logic              r_tc;
   logic              r_err;
   logic              r_ior_q;
   logic              r_iow_q;
   logic              r_rd_act;
   logic              r_wr_act;
   logic [DATA_W-1:0] r_wdata;

   dir_t              w_dir;
   logic              w_dev2mem;
   logic              w_xfer;
   logic              w_rd_rise;
   logic              w_wr_rise;
   logic              w_complete;
   logic              w_strobe_low;
   logic              w_err;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_ready;
   logic              w_ready_next;
   logic [DATA_W-1:0] w_push_data;
   logic [DATA_W-1:0] w_head;
   logic [DATA_W-1:0] w_bus_data;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_count_next;

   assign w_dir     = dir_t'(dir);
   assign w_dev2mem = (w_dir == DEV2MEM);
   assign w_xfer    = (r_state == XFER);

   // A strobe opened in XFER completes on its rising edge even if EOP moved the FSM to HOLD meanwhile.
   assign w_rd_rise    = w_dev2mem & r_rd_act & bus.IOR_N;
   assign w_wr_rise    = ~w_dev2mem & r_wr_act & bus.IOW_N;
   assign w_complete   = w_rd_rise | w_wr_rise;
   assign w_strobe_low = w_dev2mem ? ~bus.IOR_N : ~bus.IOW_N;
   assign w_err        = bus.DACK & (w_dev2mem ? (~bus.IOW_N & r_iow_q) : (~bus.IOR_N & r_ior_q));

   // A bus pop this cycle frees a slot, so a full FIFO can still take a local byte.
   assign src_ready   = w_dev2mem & (~w_full | w_rd_rise);
   assign snk_valid   = ~w_dev2mem & ~w_empty;
   assign w_push      = w_dev2mem ? (src_valid & src_ready) : w_wr_rise;
   assign w_pop       = w_dev2mem ? w_rd_rise : (snk_valid & snk_ready);
   assign w_push_data = w_dev2mem ? src_data : r_wdata;

   assign w_ready      = w_dev2mem ? (w_count != '0) : (w_count != DEPTH_C);
   assign w_ready_next = w_dev2mem ? (w_count_next != '0) : (w_count_next != DEPTH_C);

   assign w_bus_data  = w_empty ? '0 : w_head;
   assign bus.DB_OUT  = w_bus_data;
   assign snk_data    = w_bus_data;
   assign bus.DB_OE   = bus.DACK & ~bus.IOR_N & w_dev2mem & w_xfer;
   assign bus.DREQ    = r_dreq;
   assign tc_flag     = r_tc;
   assign strobe_err  = r_err;

   dma_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK          (CLK),
      .RESET        (RESET),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_data       (w_push_data),
      .o_data       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (w_count),
      .o_count_next (w_count_next)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_ior_q  <= 1'b1;
         r_iow_q  <= 1'b1;
         r_rd_act <= 1'b0;
         r_wr_act <= 1'b0;
         r_err    <= 1'b0;
         r_wdata  <= '0;
      end else begin
         r_ior_q  <= bus.IOR_N;
         r_iow_q  <= bus.IOW_N;
         r_err    <= w_err;
         r_rd_act <= enable & ~bus.IOR_N & w_dev2mem & (r_rd_act | (w_xfer & bus.DACK));
         r_wr_act <= enable & ~bus.IOW_N & ~w_dev2mem & (r_wr_act | (w_xfer & bus.DACK));
         if (~bus.IOW_N & ~w_dev2mem & (r_wr_act | (w_xfer & bus.DACK)))
            r_wdata <= bus.DB_IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_dreq  <= 1'b0;
         r_tc    <= 1'b0;
      end else if (!enable) begin
         r_state <= IDLE;
         r_dreq  <= 1'b0;
         r_tc    <= 1'b0;
      end else if (!bus.EOP_N && bus.DACK) begin
         r_state <= HOLD;
         r_dreq  <= 1'b0;
         r_tc    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ready && !r_tc) begin
                  r_state <= REQ;
                  r_dreq  <= 1'b1;
               end else begin
                  r_dreq  <= 1'b0;
               end
            end
            REQ: begin
               r_dreq <= 1'b1;
               if (bus.DACK) r_state <= XFER;
            end
            XFER: begin
               if (w_complete) begin
                  if (demand && w_ready_next) begin
                     r_dreq <= 1'b1;
                  end else begin
                     r_state <= HOLD;
                     r_dreq  <= 1'b0;
                  end
               end else if (!bus.DACK && !w_strobe_low) begin
                  r_state <= w_ready ? REQ : IDLE;
                  r_dreq  <= w_ready;
               end
            end
            HOLD: begin
               r_dreq <= 1'b0;
               if (!bus.DACK) r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_dreq  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dma_io_endpoint.sv
// Bench for dma_io_endpoint: cycle vector table, directed corner sequences, randomized bus reads vs a queue model.
module tb_dma_io_endpoint;
   import dma_io_endpoint_pkg::*;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       enable, dir, demand;
   logic       src_valid, src_ready, snk_valid, snk_ready;
   logic [7:0] src_data, snk_data;
   logic       tc_flag, strobe_err;
   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] q[$];

   dma_io_endpoint_if #(.DATA_W(8)) bus ();

   dma_io_endpoint #(.DATA_W(8), .FIFO_DEPTH(8)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .enable     (enable),
      .dir        (dir),
      .demand     (demand),
      .bus        (bus),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_data   (src_data),
      .snk_valid  (snk_valid),
      .snk_ready  (snk_ready),
      .snk_data   (snk_data),
      .tc_flag    (tc_flag),
      .strobe_err (strobe_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       en, dr, dm, sv;
      logic [7:0] sd;
      logic       dack, ior_n, iow_n, eop_n;
      logic       e_dreq, e_oe;
      logic [7:0] e_db;
      logic       e_tc, e_err;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.DACK  = 1'b0;
      bus.IOR_N = 1'b1;
      bus.IOW_N = 1'b1;
      bus.EOP_N = 1'b1;
      bus.DB_IN = 8'h00;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      bus_idle();
      enable = 1'b0; dir = 1'b0; demand = 1'b0;
      src_valid = 1'b0; src_data = 8'h00; snk_ready = 1'b0;
      tick(); tick();
      RESET = 1'b0;
   endtask

   task automatic push_local(input logic [7:0] b);
      src_valid = 1'b1;
      src_data  = b;
      tick();
      src_valid = 1'b0;
   endtask

   task automatic wait_dreq(input int max_cyc);
      int n = 0;
      while (bus.DREQ !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      check("dreq_wait", 32'(bus.DREQ), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_dreq", 32'(bus.DREQ), 0);
      check("rst_oe", 32'(bus.DB_OE), 0);
      check("rst_db", 32'(bus.DB_OUT), 0);
      check("rst_tc", 32'(tc_flag), 0);
      check("rst_err", 32'(strobe_err), 0);
      check("rst_snkv", 32'(snk_valid), 0);
      check("rst_srdy", 32'(src_ready), 1);

      // Single-mode read, then wrong-direction strobe, then DACK drop and disable
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,8'hA5,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,8'hA5,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,8'h3C,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,8'hA5,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,8'hA5,1'b0,1'b0};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,8'hA5,1'b0,1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,8'hA5,1'b0,1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,8'h3C,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,8'h3C,1'b0,1'b0};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,8'h3C,1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,8'h3C,1'b0,1'b0};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,8'h3C,1'b0,1'b1};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,8'h3C,1'b0,1'b0};
      vecs[11] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,8'h3C,1'b0,1'b0};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,8'h3C,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,8'h3C,1'b0,1'b0};
      for (int i = 0; i < 14; i++) begin
         enable = vecs[i].en; dir = vecs[i].dr; demand = vecs[i].dm;
         src_valid = vecs[i].sv; src_data = vecs[i].sd;
         bus.DACK = vecs[i].dack; bus.IOR_N = vecs[i].ior_n;
         bus.IOW_N = vecs[i].iow_n; bus.EOP_N = vecs[i].eop_n;
         tick();
         check($sformatf("v%0d_dreq", i), 32'(bus.DREQ), 32'(vecs[i].e_dreq));
         check($sformatf("v%0d_oe", i), 32'(bus.DB_OE), 32'(vecs[i].e_oe));
         check($sformatf("v%0d_db", i), 32'(bus.DB_OUT), 32'(vecs[i].e_db));
         check($sformatf("v%0d_tc", i), 32'(tc_flag), 32'(vecs[i].e_tc));
         check($sformatf("v%0d_err", i), 32'(strobe_err), 32'(vecs[i].e_err));
      end
      src_valid = 1'b0;

      // Demand-mode writes: eight bytes under one DACK fill the FIFO
      do_reset();
      enable = 1'b1; dir = 1'b1; demand = 1'b1;
      wait_dreq(4);
      bus.DACK = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         bus.IOW_N = 1'b0; bus.DB_IN = 8'(i);
         tick(); tick();
         bus.IOW_N = 1'b1;
         tick();
         check($sformatf("wr%0d_dreq", i), 32'(bus.DREQ), (i < 8) ? 1 : 0);
      end
      bus_idle();
      tick();
      snk_ready = 1'b1;
      #1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("snk%0d_valid", i), 32'(snk_valid), 1);
         check($sformatf("snk%0d_data", i), 32'(snk_data), i);
         tick();
      end
      check("snk_drained", 32'(snk_valid), 0);
      snk_ready = 1'b0;

      // EOP during the 3rd read of a demand burst
      do_reset();
      enable = 1'b1; dir = 1'b0; demand = 1'b1;
      for (int i = 0; i < 5; i++) push_local(8'(8'h10 + i));
      wait_dreq(4);
      bus.DACK = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         bus.IOR_N = 1'b0; tick();
         bus.IOR_N = 1'b1; tick();
      end
      check("eop_pre_dreq", 32'(bus.DREQ), 1);
      bus.IOR_N = 1'b0; bus.EOP_N = 1'b0;
      tick();
      bus.IOR_N = 1'b1; bus.EOP_N = 1'b1;
      tick();
      check("eop_tc", 32'(tc_flag), 1);
      check("eop_dreq", 32'(bus.DREQ), 0);
      check("eop_db", 32'(bus.DB_OUT), 8'h13);
      bus.DACK = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("eop_dreq_hold", 32'(bus.DREQ), 0);
      enable = 1'b0;
      tick();
      check("eop_tc_clr", 32'(tc_flag), 0);
      enable = 1'b1;
      tick();
      check("eop_dreq_rearm", 32'(bus.DREQ), 1);

      // Full FIFO: local push and bus pop in the same cycle
      do_reset();
      enable = 1'b1; dir = 1'b0; demand = 1'b0;
      for (int i = 0; i < 8; i++) push_local(8'(8'h20 + i));
      check("full_srdy", 32'(src_ready), 0);
      bus.DACK = 1'b1;
      tick();
      bus.IOR_N = 1'b0;
      tick();
      bus.IOR_N = 1'b1; src_valid = 1'b1; src_data = 8'h28;
      #1;
      check("full_srdy_pop", 32'(src_ready), 1);
      tick();
      src_valid = 1'b0;
      check("full_cnt", 32'(dut.w_count), 8);
      check("full_head", 32'(bus.DB_OUT), 8'h21);
      bus_idle();
      enable = 1'b0; dir = 1'b1; snk_ready = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("full_ord%0d", i), 32'(snk_data), 8'h21 + i);
         tick();
      end
      check("full_empty", 32'(snk_valid), 0);
      snk_ready = 1'b0;

      // Reset mid-transfer
      do_reset();
      enable = 1'b1;
      push_local(8'h55);
      push_local(8'h66);
      wait_dreq(4);
      bus.DACK = 1'b1;
      tick();
      bus.IOR_N = 1'b0;
      tick();
      check("mid_oe", 32'(bus.DB_OE), 1);
      RESET = 1'b1;
      tick();
      check("mrst_dreq", 32'(bus.DREQ), 0);
      check("mrst_oe", 32'(bus.DB_OE), 0);
      check("mrst_cnt", 32'(dut.w_count), 0);
      check("mrst_state", 32'(dut.r_state), 32'(IDLE));
      RESET = 1'b0;
      bus_idle();
      tick();

      // Randomized local pushes and single-mode bus reads against a queue model
      do_reset();
      enable = 1'b1; dir = 1'b0; demand = 1'b0;
      q.delete();
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) != 0) begin
            logic [7:0] b;
            b = 8'($urandom);
            src_data = b; src_valid = 1'b1;
            #1;
            check("rnd_srdy", 32'(src_ready), (q.size() < 8) ? 1 : 0);
            tick();
            src_valid = 1'b0;
            if (q.size() < 8) q.push_back(b);
         end else if (q.size() > 0) begin
            wait_dreq(4);
            bus.DACK = 1'b1;
            tick();
            bus.IOR_N = 1'b0;
            tick();
            check("rnd_oe", 32'(bus.DB_OE), 1);
            check("rnd_db", 32'(bus.DB_OUT), 32'(q[0]));
            bus.IOR_N = 1'b1;
            tick();
            void'(q.pop_front());
            check("rnd_dreq_off", 32'(bus.DREQ), 0);
            check("rnd_head", 32'(bus.DB_OUT), (q.size() > 0) ? 32'(q[0]) : 0);
            bus.DACK = 1'b0;
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
